unary_expander: RTL and testbench
=================================

# unary_expander

Inverse companion to `Counting1s`: takes a ones-count and builds an N-bit thermometer-coded word holding exactly that many ones, one bit per clock. The block sits between a count producer and any consumer that needs a fill mask, for example rate masks or fill-level indicators. Feeding its output back into `Counting1s` must return the original count; benches use this loopback check. Valid/ready handshakes on both sides.

## Interface
- `N`, default 20: output word width; must be ≥ 1.
- `W`, localparam, `$clog2(N+1)`: count width. N=20 gives W=5.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: `in_count` is valid.
- `in_ready`  out  1: block can accept a count.
- `in_count`  in  W: requested number of ones, 0..2^W−1.
- `out_valid`  out  1: `out_vec` and `out_sat` are valid and held.
- `out_ready`  in  1: consumer accepts the result.
- `out_vec`  out  N: thermometer word; bits [k−1:0] = 1, all others 0.
- `out_sat`  out  1: the request exceeded N and was clamped.

## Operation
- State machine has three states: IDLE, BUILD, HOLD.
- IDLE
  - `in_ready`=1, `out_valid`=0.
  - On an edge with `in_valid`=1: latch k = min(`in_count`, N).
  - On the same edge: set `sat` = (`in_count` > N), clear the shift register to 0, clear the bit counter to 0, go to BUILD.
- BUILD
  - `in_ready`=0, `out_valid`=0.
  - Each edge: shift register shifts right by one; the new MSB is 1 if remaining ones > 0, else 0.
  - Each edge: remaining ones decrement, saturating at 0; bit counter increments.
  - After N shifts, the first-inserted bits reach the LSBs, giving bits [k−1:0] set.
  - The edge that performs shift N goes to HOLD.
- HOLD
  - `out_valid`=1, `in_ready`=0.
  - `out_vec` and `out_sat` are stable until the handshake.
  - On an edge with `out_ready`=1: go to IDLE.
  - `out_vec` keeps its value in IDLE until the next acceptance clears it.
- `in_count` values between N+1 and 2^W−1 produce an all-ones word with `out_sat`=1.
- `in_count`=0 produces an all-zero word with `out_sat`=0.
- `in_count`=N produces an all-ones word with `out_sat`=0.
- `in_valid` is ignored outside IDLE; no requests are queued.
- `out_vec` has no meaning while `out_valid`=0; it shows partial builds during BUILD.
- Invariant: whenever `out_valid`=1, popcount(`out_vec`) = min(`in_count`, N), and the ones are contiguous from bit 0.

## Timing
- Reset (`rst_n`=0, asynchronous) forces:
  - state = IDLE
  - `in_ready`=1, `out_valid`=0, `out_vec`=0, `out_sat`=0
  - internal counters = 0
- Reset mid-BUILD or mid-HOLD abandons the request; no result is produced.
- Release from reset is synchronous to `clk`; the first acceptance can happen on the first edge after `rst_n` rises.
- Latency: acceptance at edge E0 means `out_valid` rises after edge E_N, i.e. N cycles later.
- Handshake completes on the first edge with `out_valid`=`out_ready`=1.
- `out_ready` held high gives `out_valid` high for exactly one cycle.
- Minimum issue interval is N+2 cycles:
  - 1 accept edge
  - N build edges
  - 1 output handshake edge, with the next accept on the following edge
- Backpressure: while `out_ready`=0, HOLD persists for any number of cycles; outputs do not change.
- The bit counter counts 0..N−1 in `$clog2(N)` bits (minimum 1 bit), with no wrap past N.

## Test plan
- Reset then `in_count`=7, `out_ready`=1 → after 20 cycles `out_valid`=1, `out_vec`=20'h0007F, `out_sat`=0; one cycle later `in_ready`=1.
- Boundary counts 0, 1, 19, 20 → `out_vec` = 20'h00000, 20'h00001, 20'h7FFFF, 20'hFFFFF; `out_sat`=0 in all cases.
- `in_count`=25 and `in_count`=31 → `out_vec`=20'hFFFFF, `out_sat`=1.
- Backpressure: `in_count`=5 with `out_ready`=0 for 10 cycles after `out_valid`:
  - `out_vec`=20'h0001F stays stable throughout;
  - `in_ready`=0 throughout;
  - a new `in_valid` pulse during this time is ignored;
  - raising `out_ready` completes exactly one transfer.
- Reset mid-operation: drop `rst_n` 8 cycles into the build of count 12 → all outputs return to reset values at once; the next request, count 3, yields 20'h00007.
- Loopback:
  - setup: 100 `$random` counts masked to 0..20, back-to-back, with `out_vec` fed into `Counting1s` (N=20);
  - every result must report ones equal to the requested count;
  - every `out_vec` must satisfy `out_vec & (out_vec+1)` = 0.

Source files
------------

// File: rtl/unary_expander.sv
// Thermometer-code builder: turns a ones-count into an N-bit word with bits [k-1:0] set,
// inserting one bit per clock from the MSB side, with valid/ready on both ends.
module unary_expander #(
    parameter int N = 20,
    localparam int W = $clog2(N + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_count,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_vec,
    output logic         out_sat
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [W-1:0]  N_W  = W'(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, BUILD, HOLD} state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  sr;
    logic [N-1:0]  sr_next;
    logic [W-1:0]  rem;
    logic [CW-1:0] bcnt;
    logic          sat;

    // Ones go in at the MSB first, so after N shifts they have walked down to bit 0.
    generate
        if (N > 1) begin : g_shift
            assign sr_next = {(rem != '0), sr[N-1:1]};
        end else begin : g_shift1
            assign sr_next = (rem != '0);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = BUILD;
            end
            BUILD: begin
                if (bcnt == LAST) state_d = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr   <= '0;
            rem  <= '0;
            bcnt <= '0;
            sat  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        rem  <= (in_count > N_W) ? N_W : in_count;
                        sat  <= (in_count > N_W);
                        sr   <= '0;
                        bcnt <= '0;
                    end
                end
                BUILD: begin
                    sr <= sr_next;
                    if (rem != '0) rem <= rem - W'(1);
                    // Parks at N-1 on the final shift rather than wrapping.
                    if (bcnt != LAST) bcnt <= bcnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign out_vec = sr;
    assign out_sat = sat;
endmodule

// File: tb/tb_unary_expander.sv
// Directed bench for unary_expander (N=20): latency, boundary counts, saturation,
// backpressure, mid-build reset and a popcount loopback over random counts.
module tb_unary_expander;
    localparam int N = 20;
    localparam int W = 5;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_count = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N-1:0] out_vec;
    logic         out_sat;

    int errors = 0;
    int checks = 0;

    unary_expander #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_count(in_count),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_vec(out_vec), .out_sat(out_sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int ones(input logic [N-1:0] v);
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(v[i]);
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request and wait for out_valid; returns the observed latency in edges.
    task automatic issue(input logic [W-1:0] c, output int lat);
        chk("in_ready_before_issue", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_count = c;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        if (!out_valid) chk("out_valid_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic req(input string tag, input logic [W-1:0] c,
                       input logic [N-1:0] ev, input logic es);
        int lat;
        out_ready = 1'b1;
        issue(c, lat);
        chk({tag, "_lat"}, 32'(lat), 32'(N));
        chk({tag, "_vec"}, 32'(out_vec), 32'(ev));
        chk({tag, "_sat"}, 32'(out_sat), 32'(es));
        tick();
        chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        chk({tag, "_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int lat;
        int seen;
        logic [N-1:0] held;
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_vec", 32'(out_vec), 32'd0);
        chk("rst_out_sat", 32'(out_sat), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        req("c7", 5'd7, 20'h0007F, 1'b0);
        req("c0", 5'd0, 20'h00000, 1'b0);
        req("c1", 5'd1, 20'h00001, 1'b0);
        req("c19", 5'd19, 20'h7FFFF, 1'b0);
        req("c20", 5'd20, 20'hFFFFF, 1'b0);
        req("c25", 5'd25, 20'hFFFFF, 1'b1);
        req("c31", 5'd31, 20'hFFFFF, 1'b1);

        // Backpressure with an ignored request pulsed during HOLD
        out_ready = 1'b0;
        issue(5'd5, lat);
        chk("bp_vec", 32'(out_vec), 32'h0001F);
        held = out_vec;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                in_valid = 1'b1;
                in_count = 5'd9;
            end
            tick();
            in_valid = 1'b0;
            chk("bp_hold_vec", 32'(out_vec), 32'(held));
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (out_valid) seen++;
        end
        chk("bp_single_transfer", 32'(seen), 32'd0);
        chk("bp_idle_ready", 32'(in_ready), 32'd1);

        // Reset 8 cycles into the build of count 12
        in_valid = 1'b1;
        in_count = 5'd12;
        tick();
        in_valid = 1'b0;
        repeat (8) tick();
        chk("mid_building", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mrst_in_ready", 32'(in_ready), 32'd1);
        chk("mrst_out_valid", 32'(out_valid), 32'd0);
        chk("mrst_out_vec", 32'(out_vec), 32'd0);
        chk("mrst_out_sat", 32'(out_sat), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        req("after_rst_c3", 5'd3, 20'h00007, 1'b0);

        // Loopback: popcount must equal the request and ones must be contiguous from bit 0
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            logic [W-1:0] c;
            logic [N-1:0] v;
            c = W'($urandom_range(0, N));
            issue(c, lat);
            v = out_vec;
            chk("loop_ones", 32'(ones(v)), 32'(c));
            chk("loop_contig", 32'(v & (v + 20'd1)), 32'd0);
            chk("loop_sat", 32'(out_sat), 32'd0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
